// File: rtl/dr_pkg.sv
// Shared four-phase dual-rail helpers and the link FSM state type.
// Functions work on a maximum-width word and take the live width as an argument.
package dr_pkg;

   localparam int RAIL_NUM     = 2;
   localparam int DR_MAX_WIDTH = 64;
   localparam int DR_WORD_BITS = DR_MAX_WIDTH * RAIL_NUM;

   typedef enum logic [1:0] {
      RX_SPACER,
      RX_DATA,
      TX_DATA,
      TX_SPACER
   } dr_state_e;

   typedef logic [DR_MAX_WIDTH-1:0][RAIL_NUM-1:0] dr_word_t;
   typedef logic [DR_MAX_WIDTH-1:0]               dr_val_t;

   // Rail 1 carries the bit value, rail 0 its complement.
   function automatic dr_word_t dr_encode(input dr_val_t val, input int width);
      dr_word_t w;
      w = '0;
      for (int i = 0; i < DR_MAX_WIDTH; i++) begin
         if (i < width) w[i] = {val[i], ~val[i]};
      end
      return w;
   endfunction

   function automatic dr_val_t dr_decode(input dr_word_t w, input int width);
      dr_val_t v;
      v = '0;
      for (int i = 0; i < DR_MAX_WIDTH; i++) begin
         if (i < width) v[i] = w[i][1];
      end
      return v;
   endfunction

   function automatic logic dr_complete(input dr_word_t w, input int width);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DR_MAX_WIDTH; i++) begin
         if (i < width && (w[i][1] == w[i][0])) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic dr_is_null(input dr_word_t w, input int width);
      logic nul;
      nul = 1'b1;
      for (int i = 0; i < DR_MAX_WIDTH; i++) begin
         if (i < width && (w[i] != '0)) nul = 1'b0;
      end
      return nul;
   endfunction

   function automatic logic dr_illegal(input dr_word_t w, input int width);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DR_MAX_WIDTH; i++) begin
         if (i < width && (w[i] == 2'b11)) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/dr_sync.sv
// Multi-stage flop chain bringing asynchronous rails into the clk domain.
module dr_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_q [STAGES];
   logic [W-1:0] stage_d [STAGES];

   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
   end

   // NOTE: every stage is cleared so a stale rail cannot look like fresh data after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/int_accum_sync.sv
// Sums COUNT operands received over a four-phase dual-rail link and returns the
// total plus a sticky carry/overflow flag over a second dual-rail link.
module int_accum_sync
   import dr_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int COUNT       = 4,
   parameter int SIGNED      = 0,
   parameter int SYNC_STAGES = 2,
   parameter     ENC         = "FP"
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [WIDTH-1:0][RAIL_NUM-1:0]   a,
   output logic                             ack_o,
   output logic [WIDTH-1:0][RAIL_NUM-1:0]   s,
   output logic [RAIL_NUM-1:0]              c_out,
   input  logic                             ack_i,
   output logic                             err
);

   localparam int RAIL_W  = WIDTH * RAIL_NUM;
   localparam int CNT_W   = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

   if (ENC != "FP")          begin : g_bad_enc   $error("int_accum_sync: only ENC=\"FP\" is supported"); end
   if (COUNT < 1)            begin : g_bad_count $error("int_accum_sync: COUNT must be >= 1"); end
   if (SYNC_STAGES < 2)      begin : g_bad_sync  $error("int_accum_sync: SYNC_STAGES must be >= 2"); end
   if (WIDTH > DR_MAX_WIDTH) begin : g_bad_width $error("int_accum_sync: WIDTH exceeds DR_MAX_WIDTH"); end

   logic [RAIL_W-1:0] a_sync;
   logic              ack_i_sync;

   dr_sync #(.W(RAIL_W), .STAGES(SYNC_STAGES)) u_sync_a (
      .clk (clk), .rst (rst), .d (a), .q (a_sync)
   );

   dr_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_ack (
      .clk (clk), .rst (rst), .d (ack_i), .q (ack_i_sync)
   );

   dr_state_e                       state_q, state_d;
   logic [WIDTH-1:0]                acc_q, acc_d;
   logic                            flag_q, flag_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            err_q, err_d;
   logic                            ack_o_q, ack_o_d;
   logic [WIDTH-1:0][RAIL_NUM-1:0]  s_q, s_d;
   logic [RAIL_NUM-1:0]             c_q, c_d;
   logic [PRIME_W-1:0]              prime_q, prime_d;

   dr_word_t         a_word;
   logic             a_null, a_illegal, a_complete, primed;
   logic [WIDTH-1:0] operand;
   logic [WIDTH:0]   sum_ext;
   logic             add_flag;

   assign a_word     = DR_WORD_BITS'(a_sync);
   assign a_null     = dr_is_null(a_word, WIDTH);
   assign a_illegal  = dr_illegal(a_word, WIDTH);
   assign a_complete = dr_complete(a_word, WIDTH);
   assign operand    = WIDTH'(dr_decode(a_word, WIDTH));
   assign sum_ext    = {1'b0, acc_q} + {1'b0, operand};
   assign add_flag   = (SIGNED != 0)
                     ? ((acc_q[WIDTH-1] == operand[WIDTH-1]) && (sum_ext[WIDTH-1] != acc_q[WIDTH-1]))
                     : sum_ext[WIDTH];

   // Synchroniser output reads as NULL until refilled after reset, so hold off
   // spacer detection until every stage carries a real pin sample.
   assign primed = (prime_q == PRIME_W'(SYNC_STAGES));

   // NOTE: every signal gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      flag_d  = flag_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ack_o_d = ack_o_q;
      s_d     = s_q;
      c_d     = c_q;
      prime_d = primed ? prime_q : prime_q + PRIME_W'(1);

      case (state_q)
         RX_SPACER: begin
            if (primed && a_null) begin
               ack_o_d = 1'b0;
               state_d = RX_DATA;
            end
         end
         RX_DATA: begin
            if (a_illegal) begin
               err_d = 1'b1;
            end else if (a_complete) begin
               acc_d   = sum_ext[WIDTH-1:0];
               flag_d  = flag_q | add_flag;
               cnt_d   = cnt_q + CNT_W'(1);
               ack_o_d = 1'b1;
               state_d = (cnt_q == CNT_W'(COUNT - 1)) ? TX_DATA : RX_SPACER;
            end
         end
         TX_DATA: begin
            s_d = RAIL_W'(dr_encode(DR_MAX_WIDTH'(acc_q), WIDTH));
            c_d = RAIL_NUM'(dr_encode(DR_MAX_WIDTH'(flag_q), 1));
            if (ack_i_sync) begin
               s_d     = '0;
               c_d     = '0;
               state_d = TX_SPACER;
            end
         end
         TX_SPACER: begin
            s_d = '0;
            c_d = '0;
            if (!ack_i_sync) begin
               acc_d   = '0;
               flag_d  = 1'b0;
               cnt_d   = '0;
               state_d = RX_SPACER;
            end
         end
         default: state_d = RX_SPACER;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_SPACER;
         acc_q   <= '0;
         flag_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ack_o_q <= 1'b0;
         s_q     <= '0;
         c_q     <= '0;
         prime_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ack_o_q <= ack_o_d;
         s_q     <= s_d;
         c_q     <= c_d;
         prime_q <= prime_d;
      end
   end

   assign ack_o = ack_o_q;
   assign s     = s_q;
   assign c_out = c_q;
   assign err   = err_q;

endmodule

// File: tb/tb_int_accum_sync.sv
// Drives an unsigned and a signed accumulator in lockstep from one dual-rail
// producer/consumer and compares against an integer-arithmetic model.
module tb_int_accum_sync;

   localparam int W = 8;
   localparam int N = 4;
   localparam int S = 2;

   typedef struct packed {
      logic [W-1:0] su;
      logic [W-1:0] ss;
      logic [1:0]   cu;
      logic [1:0]   cs;
      logic [W-1:0] es;
      logic [1:0]   ecu;
      logic [1:0]   ecs;
   } res_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [W-1:0][1:0] a;
   logic              ack_i;
   logic              ack_o_u, ack_o_s, err_u, err_s;
   logic [W-1:0][1:0] s_u, s_s;
   logic [1:0]        c_u, c_s;

   int tests = 0;
   int fails = 0;
   int ack_rises = 0;
   int s_valids = 0;
   logic ack_prev = 1'b0;
   bit   s_prev_valid = 1'b0;
   logic [W-1:0] model_q[$];

   always #5 clk = ~clk;

   int_accum_sync #(.WIDTH(W), .COUNT(N), .SIGNED(0), .SYNC_STAGES(S), .ENC("FP")) u_dut_u (
      .clk(clk), .rst(rst), .a(a), .ack_o(ack_o_u), .s(s_u), .c_out(c_u), .ack_i(ack_i), .err(err_u)
   );

   int_accum_sync #(.WIDTH(W), .COUNT(N), .SIGNED(1), .SYNC_STAGES(S), .ENC("FP")) u_dut_s (
      .clk(clk), .rst(rst), .a(a), .ack_o(ack_o_s), .s(s_s), .c_out(c_s), .ack_i(ack_i), .err(err_s)
   );

   function automatic logic [W-1:0][1:0] enc(input logic [W-1:0] v);
      logic [W-1:0][1:0] r;
      for (int i = 0; i < W; i++) r[i] = {v[i], ~v[i]};
      return r;
   endfunction

   function automatic logic [W-1:0] dec(input logic [W-1:0][1:0] x);
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) v[i] = x[i][1];
      return v;
   endfunction

   function automatic bit is_valid(input logic [W-1:0][1:0] x);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < W; i++) if (x[i] !== 2'b01 && x[i] !== 2'b10) ok = 1'b0;
      return ok;
   endfunction

   always @(negedge clk) begin
      if (ack_o_u === 1'b1 && ack_prev !== 1'b1) ack_rises++;
      ack_prev = ack_o_u;
      if (is_valid(s_u) && !s_prev_valid) s_valids++;
      s_prev_valid = is_valid(s_u);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack_low();
      int n;
      n = 0;
      while (ack_o_u !== 1'b0 && n < 300) begin @(negedge clk); n++; end
      tests++;
      if (ack_o_u !== 1'b0) begin
         fails++;
         $display("FAIL ack_low_wait: ack_o=%b, required 0 within 300 cycles", ack_o_u);
      end
   endtask

   task automatic send(input logic [W-1:0] v, output int lat);
      int n;
      wait_ack_low();
      a = enc(v);
      model_q.push_back(v);
      n = 0;
      do begin @(negedge clk); n++; end while (ack_o_u !== 1'b1 && n < 300);
      lat = n;
      tests++;
      if (ack_o_u !== 1'b1) begin
         fails++;
         $display("FAIL ack_high_wait: ack_o=%b, required 1 within 300 cycles", ack_o_u);
      end
      a = '0;
   endtask

   task automatic wait_result(output res_t r);
      int n, u, sg;
      bit fu, fs;
      n = 0;
      while (!is_valid(s_u) && n < 300) begin @(negedge clk); n++; end
      tests++;
      if (!is_valid(s_u)) begin
         fails++;
         $display("FAIL result_wait: s=%h never became valid, required valid within 300 cycles", s_u);
      end
      r.su = dec(s_u);
      r.ss = dec(s_s);
      r.cu = c_u;
      r.cs = c_s;
      u = 0; sg = 0; fu = 1'b0; fs = 1'b0;
      foreach (model_q[i]) begin
         int op_s;
         u = u + int'(model_q[i]);
         if (u > 255) fu = 1'b1;
         u = u % 256;
         op_s = (model_q[i] >= 128) ? int'(model_q[i]) - 256 : int'(model_q[i]);
         sg = sg + op_s;
         if (sg > 127 || sg < -128) fs = 1'b1;
         sg = ((sg + 384) % 256) - 128;
      end
      r.es  = W'(u);
      r.ecu = fu ? 2'b10 : 2'b01;
      r.ecs = fs ? 2'b10 : 2'b01;
   endtask

   task automatic release_result(input int hold);
      int n;
      tick(hold);
      ack_i = 1'b1;
      n = 0;
      while ((s_u !== '0 || s_s !== '0 || c_u !== 2'b00) && n < 300) begin @(negedge clk); n++; end
      tests++;
      if (s_u !== '0 || s_s !== '0 || c_u !== 2'b00) begin
         fails++;
         $display("FAIL null_wait: s=%h c_out=%b, required NULL within 300 cycles", s_u, c_u);
      end
      ack_i = 1'b0;
      model_q.delete();
   endtask

   task automatic run_batch(input logic [W-1:0] ops [N], input int hold, output res_t r);
      int lat;
      for (int i = 0; i < N; i++) send(ops[i], lat);
      wait_result(r);
      release_result(hold);
   endtask

   task automatic random_batch(input int hold, output res_t r);
      logic [W-1:0] ops [N];
      for (int i = 0; i < N; i++) ops[i] = W'($urandom_range(0, 255));
      run_batch(ops, hold, r);
   endtask

   task automatic test_reset();
      a = '0;
      ack_i = 1'b0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tests++;
      if ({ack_o_u, ack_o_s, err_u, err_s, s_u, s_s, c_u, c_s} !== '0) begin
         fails++;
         $display("FAIL reset_state: ack_o=%b%b err=%b%b s=%h/%h c_out=%b/%b, required all 0",
                  ack_o_u, ack_o_s, err_u, err_s, s_u, s_s, c_u, c_s);
      end
      tick(10);
   endtask

   task automatic test_unsigned_sum();
      int r0, v0, lat;
      res_t r;
      r0 = ack_rises;
      v0 = s_valids;
      send(8'd1, lat);
      tests++;
      if (lat !== S + 1) begin
         fails++;
         $display("FAIL ack_latency: got %0d cycles, required %0d", lat, S + 1);
      end
      send(8'd2, lat);
      send(8'd3, lat);
      send(8'd4, lat);
      wait_result(r);
      release_result(0);
      tick(5);
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {8'd10, 8'd10, 2'b01, 2'b01}) begin
         fails++;
         $display("FAIL unsigned_sum: got s=%0d/%0d c_out=%b/%b, required s=10/10 c_out=01/01",
                  r.su, r.ss, r.cu, r.cs);
      end
      tests++;
      if ((ack_rises - r0) !== N || (s_valids - v0) !== 1) begin
         fails++;
         $display("FAIL handshake_count: got %0d ack_o pulses %0d s data phases, required 4 and 1",
                  ack_rises - r0, s_valids - v0);
      end
   endtask

   task automatic test_carry();
      res_t r;
      run_batch('{8'd200, 8'd100, 8'd0, 8'd0}, 0, r);
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {8'd44, 8'd44, 2'b10, 2'b01}) begin
         fails++;
         $display("FAIL unsigned_carry: got s=%0d/%0d c_out=%b/%b, required s=44/44 c_out=10/01",
                  r.su, r.ss, r.cu, r.cs);
      end
      run_batch('{8'd1, 8'd1, 8'd1, 8'd1}, 0, r);
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {8'd4, 8'd4, 2'b01, 2'b01}) begin
         fails++;
         $display("FAIL carry_cleared: got s=%0d/%0d c_out=%b/%b, required s=4/4 c_out=01/01",
                  r.su, r.ss, r.cu, r.cs);
      end
   endtask

   task automatic test_signed();
      res_t r;
      run_batch('{8'd100, 8'd50, 8'd246, 8'd0}, 0, r);
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {8'd140, 8'd140, 2'b10, 2'b10}) begin
         fails++;
         $display("FAIL signed_overflow: got s=%0d/%0d c_out=%b/%b, required s=140/140 c_out=10/10",
                  r.su, r.ss, r.cu, r.cs);
      end
      run_batch('{8'd246, 8'd20, 8'd1, 8'd0}, 0, r);
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {8'd11, 8'd11, 2'b10, 2'b01}) begin
         fails++;
         $display("FAIL signed_no_overflow: got s=%0d/%0d c_out=%b/%b, required s=11/11 c_out=10/01",
                  r.su, r.ss, r.cu, r.cs);
      end
   endtask

   task automatic test_backpressure();
      res_t r;
      logic [W-1:0][1:0] held;
      int bad, r0, lat;
      for (int i = 0; i < N; i++) send(W'($urandom_range(0, 255)), lat);
      wait_result(r);
      held = s_u;
      r0 = ack_rises;
      a = enc(8'h07);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (s_u !== held || ack_o_u !== 1'b1) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL backpressure_hold: %0d cycles with s or ack_o disturbed, required 0", bad);
      end
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {r.es, r.es, r.ecu, r.ecs}) begin
         fails++;
         $display("FAIL backpressure_sum: got s=%0d/%0d c_out=%b/%b, required s=%0d c_out=%b/%b",
                  r.su, r.ss, r.cu, r.cs, r.es, r.ecu, r.ecs);
      end
      release_result(0);
      tick(20);
      tests++;
      if (ack_o_u !== 1'b1 || ack_rises !== r0) begin
         fails++;
         $display("FAIL held_word_not_taken: ack_o=%b new pulses=%0d, required 1 and 0",
                  ack_o_u, ack_rises - r0);
      end
      a = '0;
      random_batch(2, r);
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {r.es, r.es, r.ecu, r.ecs}) begin
         fails++;
         $display("FAIL after_backpressure_sum: got s=%0d/%0d c_out=%b/%b, required s=%0d c_out=%b/%b",
                  r.su, r.ss, r.cu, r.cs, r.es, r.ecu, r.ecs);
      end
   endtask

   task automatic test_illegal();
      res_t r;
      int r0, lat;
      wait_ack_low();
      r0 = ack_rises;
      a = enc(8'd5);
      a[3] = 2'b11;
      tick(12);
      tests++;
      if ({err_u, err_s, ack_o_u} !== 3'b110 || ack_rises !== r0) begin
         fails++;
         $display("FAIL illegal_code: err=%b%b ack_o=%b pulses=%0d, required err=11 ack_o=0 pulses=0",
                  err_u, err_s, ack_o_u, ack_rises - r0);
      end
      send(8'd5, lat);
      send(8'd0, lat);
      send(8'd0, lat);
      send(8'd0, lat);
      wait_result(r);
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {8'd5, 8'd5, 2'b01, 2'b01}) begin
         fails++;
         $display("FAIL illegal_recovery: got s=%0d/%0d c_out=%b/%b, required s=5/5 c_out=01/01",
                  r.su, r.ss, r.cu, r.cs);
      end
      tests++;
      if ({err_u, err_s} !== 2'b11) begin
         fails++;
         $display("FAIL err_sticky: err=%b%b, required 11", err_u, err_s);
      end
      release_result(0);
   endtask

   task automatic test_reset_mid();
      res_t r;
      int r0, lat;
      send(W'($urandom_range(0, 255)), lat);
      send(W'($urandom_range(0, 255)), lat);
      wait_ack_low();
      a = enc(W'($urandom_range(0, 255)));
      tick(6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      model_q.delete();
      tests++;
      if ({ack_o_u, ack_o_s, err_u, err_s, s_u, s_s, c_u, c_s} !== '0) begin
         fails++;
         $display("FAIL reset_mid_state: ack_o=%b%b err=%b%b s=%h/%h c_out=%b/%b, required all 0",
                  ack_o_u, ack_o_s, err_u, err_s, s_u, s_s, c_u, c_s);
      end
      r0 = ack_rises;
      tick(20);
      tests++;
      if (ack_o_u !== 1'b0 || ack_rises !== r0) begin
         fails++;
         $display("FAIL reset_held_word: ack_o=%b pulses=%0d, required 0 and 0", ack_o_u, ack_rises - r0);
      end
      a = '0;
      tick(10);
      random_batch(1, r);
      tests++;
      if ({r.su, r.ss, r.cu, r.cs} !== {r.es, r.es, r.ecu, r.ecs}) begin
         fails++;
         $display("FAIL reset_fresh_sum: got s=%0d/%0d c_out=%b/%b, required s=%0d c_out=%b/%b",
                  r.su, r.ss, r.cu, r.cs, r.es, r.ecu, r.ecs);
      end
   endtask

   task automatic test_random();
      res_t r;
      for (int b = 0; b < 8; b++) begin
         random_batch($urandom_range(0, 5), r);
         tests++;
         if ({r.su, r.ss, r.cu, r.cs} !== {r.es, r.es, r.ecu, r.ecs}) begin
            fails++;
            $display("FAIL random_batch_%0d: got s=%0d/%0d c_out=%b/%b, required s=%0d c_out=%b/%b",
                     b, r.su, r.ss, r.cu, r.cs, r.es, r.ecu, r.ecs);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_sum();
      test_carry();
      test_signed();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded 50000 cycles, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
